// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush
// bubbles and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rdata1,
    input  logic [XLEN-1:0]  id_rdata2,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [3:0]       id_funct4,
    input  logic [7:0]       id_ctrl,
    input  logic             flush,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rdata1,
    output logic [XLEN-1:0]  ex_rdata2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [3:0]       ex_funct4,
    output logic [7:0]       ex_ctrl,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  pc_q, pc_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d, imm_q, imm_d;
    logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [3:0]       funct4_q, funct4_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             hz, kill;

    // ctrl[6] is memread: a load in EX whose rd feeds a source read in ID
    assign hz = id_valid & valid_q & ctrl_q[6] & (rd_q != 5'd0) &
                ((id_uses_rs1 & (rd_q == id_rs1)) | (id_uses_rs2 & (rd_q == id_rs2)));
    assign kill  = flush | hz;
    assign stall = hz & ~flush & ~reset;

    always_comb begin
        valid_d     = ~kill & id_valid;
        pc_d        = kill ? '0 : id_pc;
        rdata1_d    = kill ? '0 : id_rdata1;
        rdata2_d    = kill ? '0 : id_rdata2;
        imm_d       = kill ? '0 : id_imm;
        rs1_d       = kill ? '0 : id_rs1;
        rs2_d       = kill ? '0 : id_rs2;
        rd_d        = kill ? '0 : id_rd;
        funct4_d    = kill ? '0 : id_funct4;
        ctrl_d      = valid_d ? id_ctrl : '0;
        stall_cnt_d = (hz & ~flush & ~&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (flush & ~&flush_cnt_q) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            funct4_q    <= '0;
            ctrl_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            funct4_q    <= funct4_d;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_pc     = pc_q;
    assign ex_rdata1 = rdata1_q;
    assign ex_rdata2 = rdata2_q;
    assign ex_imm    = imm_q;
    assign ex_rs1    = rs1_q;
    assign ex_rs2    = rs2_q;
    assign ex_rd     = rd_q;
    assign ex_funct4 = funct4_q;
    assign ex_ctrl   = ctrl_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; a second instance with
// 2-bit counters exercises counter saturation.
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        reset, id_valid, id_uses_rs1, id_uses_rs2, flush;
    logic [63:0] id_pc, id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct4;
    logic [7:0]  id_ctrl;

    logic        ex_valid, stall;
    logic [63:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct4;
    logic [7:0]  ex_ctrl;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_valid, s_stall;
    logic [63:0] s_pc, s_rdata1, s_rdata2, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [3:0]  s_funct4;
    logic [7:0]  s_ctrl;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_funct4(id_funct4), .id_ctrl(id_ctrl), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1),
        .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct4(ex_funct4),
        .ex_ctrl(ex_ctrl), .stall(stall), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.XLEN(64), .CNT_W(2)) sat (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_funct4(id_funct4), .id_ctrl(id_ctrl), .flush(flush),
        .ex_valid(s_valid), .ex_pc(s_pc), .ex_rdata1(s_rdata1),
        .ex_rdata2(s_rdata2), .ex_imm(s_imm), .ex_rs1(s_rs1),
        .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct4(s_funct4),
        .ex_ctrl(s_ctrl), .stall(s_stall), .stall_cnt(s_stall_cnt),
        .flush_cnt(s_flush_cnt)
    );

    typedef struct packed {
        logic        v;
        logic [63:0] pc, r1, r2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  f4;
        logic [7:0]  ctrl;
        logic [31:0] sc, fc;
        logic [1:0]  sc2, fc2;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic set_ins(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                           input logic u2, input logic [7:0] ctrl);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_uses_rs1 = u1; id_uses_rs2 = u2; id_ctrl = ctrl;
        id_rdata1 = {$urandom, $urandom}; id_rdata2 = {$urandom, $urandom};
        id_imm = {$urandom, $urandom}; id_funct4 = 4'($urandom);
    endtask

    task automatic cycle();
        exp_t n, e;
        logic hz;
        #1;
        hz = id_valid & m.v & m.ctrl[6] & (m.rd != 5'd0) &
             ((id_uses_rs1 & (m.rd == id_rs1)) | (id_uses_rs2 & (m.rd == id_rs2)));
        chk("stall", {stall, s_stall}, {2{hz & ~flush & ~reset}});
        n = '0;
        if (!reset) begin
            n.sc = m.sc; n.fc = m.fc; n.sc2 = m.sc2; n.fc2 = m.fc2;
            if (flush) begin
                n.fc  = m.fc + 32'(m.fc != '1);
                n.fc2 = m.fc2 + 2'(m.fc2 != 2'b11);
            end else if (hz) begin
                n.sc  = m.sc + 32'(m.sc != '1);
                n.sc2 = m.sc2 + 2'(m.sc2 != 2'b11);
            end else begin
                n.v = id_valid; n.pc = id_pc; n.r1 = id_rdata1; n.r2 = id_rdata2;
                n.imm = id_imm; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
                n.f4 = id_funct4; n.ctrl = id_valid ? id_ctrl : 8'h00;
            end
        end
        sb.push_back(n);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_rdata1", ex_rdata1, e.r1);
            chk("ex_rdata2", ex_rdata2, e.r2);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_misc", 64'({ex_valid, ex_rs1, ex_rs2, ex_rd, ex_funct4, ex_ctrl}),
                64'({e.v, e.rs1, e.rs2, e.rd, e.f4, e.ctrl}));
            chk("counters", {stall_cnt, flush_cnt}, {e.sc, e.fc});
            chk("sat_counters", 64'({s_stall_cnt, s_flush_cnt}), 64'({e.sc2, e.fc2}));
            chk("sat_data", s_pc ^ s_rdata1 ^ s_rdata2 ^ s_imm, e.pc ^ e.r1 ^ e.r2 ^ e.imm);
            chk("sat_misc", 64'({s_valid, s_rs1, s_rs2, s_rd, s_funct4, s_ctrl}),
                64'({e.v, e.rs1, e.rs2, e.rd, e.f4, e.ctrl}));
            m = e;
        end
    endtask

    initial begin
        m = '0;
        reset = 1'b1; flush = 1'b0;
        set_ins(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        m = '0;
        cycle();
        reset = 1'b0;
        set_ins(1'b1, 64'h100, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 8'h81);
        id_rdata1 = 64'd12; id_rdata2 = 64'd13;
        cycle();
        chk("basic_pc", ex_pc, 64'h100);
        chk("basic_ctrl", 64'(ex_ctrl), 64'h81);
        set_ins(1'b1, 64'h104, 5'd3, 5'd0, 5'd12, 1'b1, 1'b0, 8'hD4);
        cycle();
        set_ins(1'b1, 64'h108, 5'd12, 5'd4, 5'd6, 1'b1, 1'b1, 8'h80);
        cycle();
        chk("loaduse_bubble", 64'({ex_valid, ex_ctrl}), 64'd0);
        chk("loaduse_cnt", 64'(stall_cnt), 64'd1);
        cycle();
        chk("loaduse_resume", ex_pc, 64'h108);
        set_ins(1'b1, 64'h10C, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 8'hD4);
        cycle();
        set_ins(1'b1, 64'h110, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 8'h80);
        cycle();
        set_ins(1'b1, 64'h114, 5'd1, 5'd2, 5'd14, 1'b1, 1'b1, 8'hD4);
        cycle();
        set_ins(1'b1, 64'h118, 5'd3, 5'd14, 5'd8, 1'b1, 1'b0, 8'h80);
        cycle();
        chk("x0_nouse_cnt", 64'(stall_cnt), 64'd1);
        set_ins(1'b1, 64'h11C, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 8'hD4);
        cycle();
        set_ins(1'b1, 64'h120, 5'd7, 5'd2, 5'd8, 1'b1, 1'b1, 8'h80);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_cnt", {stall_cnt, flush_cnt}, {32'd1, 32'd1});
        set_ins(1'b1, 64'h124, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 8'hD4);
        cycle();
        set_ins(1'b1, 64'h128, 5'd9, 5'd2, 5'd8, 1'b1, 1'b1, 8'h80);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("reset_midstall", 64'({ex_valid, ex_ctrl, stall_cnt[7:0], flush_cnt[7:0]}), 64'd0);
        for (int i = 0; i < 5; i++) begin
            set_ins(1'b1, 64'h200 + 64'(i * 8), 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 8'hD4);
            cycle();
            set_ins(1'b1, 64'h204 + 64'(i * 8), 5'd2, 5'd10, 5'd11, 1'b0, 1'b1, 8'h80);
            cycle();
            cycle();
        end
        chk("sat_stall", 64'(s_stall_cnt), 64'd3);
        for (int i = 0; i < 300; i++) begin
            set_ins($urandom_range(0, 3) != 0, {$urandom, $urandom}, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                    1'($urandom), 8'($urandom));
            flush = $urandom_range(0, 7) == 0;
            reset = $urandom_range(0, 40) == 0;
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the register file in the 5-stage RV64 pipeline.
- Captures the register-file read data, register indices, immediate, funct bits and decode control each cycle, and presents them to EX.
- Contains the load-use hazard detector, which generates the stall back to IF/ID and inserts bubbles.
- Supports flush from branch resolution and keeps stall/bubble performance counters.

Parameters:
XLEN, 64, datapath width (PC, read data, immediate)
CNT_W, 32, width of performance counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
id_valid  input  1  decode slot holds a real instruction
id_pc  input  XLEN  PC of decode instruction
id_rdata1  input  XLEN  register-file ReadData1
id_rdata2  input  XLEN  register-file ReadData2
id_imm  input  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  input  5 each  register indices
id_uses_rs1, id_uses_rs2  input  1 each  instruction actually reads rs1/rs2
id_funct4  input  4  {instr[30], instr[14:12]}
id_ctrl  input  8  {regwrite, memread, memwrite, memtoreg, branch, alusrc, aluop[1:0]}
flush  input  1  taken branch/jump resolved downstream; kill decode slot
ex_valid  output  1  EX slot holds a real instruction
ex_pc, ex_rdata1, ex_rdata2, ex_imm  output  XLEN  registered copies
ex_rs1, ex_rs2, ex_rd  output  5 each  registered indices
ex_funct4  output  4  registered funct bits
ex_ctrl  output  8  registered control; all-zero for a bubble
stall  output  1  combinational; hold PC and IF/ID this cycle
stall_cnt, flush_cnt  output  CNT_W each  saturating event counters

Behaviour:
- Hazard (combinational):
  - hz = id_valid & ex_valid & ex_ctrl[memread] & (ex_rd != 0) & ((id_uses_rs1 & ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2)).
  - stall = hz & !flush & !reset.
- Register update on rising clk, highest priority first:
  1. reset: every ex_* output = 0, ex_valid = 0, stall_cnt = 0, flush_cnt = 0.
  2. flush: load a bubble. ex_valid = 0, ex_ctrl = 0, all other ex_* = 0. flush_cnt +1.
  3. stall: load a bubble (same as flush). stall_cnt +1. IF/ID is held upstream, so the same instruction is presented again next cycle.
  4. else: load all id_* fields. ex_valid = id_valid. ex_ctrl = id_valid ? id_ctrl : 0.
- Latency: exactly 1 cycle, decode to EX. No combinational path from id_* to ex_* outputs.
- A load followed by a dependent instruction yields exactly one bubble. On the next cycle ex_ctrl[memread] = 0, so hz deasserts.
- x0 never causes a stall, even when the load targets x0.
- Counters saturate at all-ones and do not wrap.
- flush and hz in the same cycle: flush wins. stall = 0, only flush_cnt increments.
- Reset mid-stall: next cycle all outputs are 0 and stall = 0. The register file needs no bypass here because it writes on negedge.
- id_valid = 0 with no flush/stall: registers a bubble and no counter changes.

Test Plan:
- Reset, then id_valid=1, id_pc=0x100, id_rdata1=12, id_rdata2=13, id_rd=5, id_ctrl=0x81 (regwrite, aluop=01) -> next cycle ex_pc=0x100, ex_rdata1=12, ex_rdata2=13, ex_rd=5, ex_ctrl=0x81, ex_valid=1, stall=0.
- ld x12 (ctrl memread=1, rd=12), then add with rs1=12, uses_rs1=1 -> stall=1 for one cycle. Next edge ex_valid=0, ex_ctrl=0, stall_cnt=1. Following cycle stall=0 and the add registers.
- ld x0 followed by an instruction with rs1=0 -> stall=0, stall_cnt stays 0. Load with rd=14 followed by an instruction with rs2=14, uses_rs2=0 -> stall=0.
- Load-use hazard present with flush=1 in the same cycle -> stall=0, bubble registered, flush_cnt=1, stall_cnt=0.
- Assert reset while stall=1 and ex_valid=1 -> next edge all ex_* = 0, counters = 0, stall=0.
- Force stall_cnt to 0xFFFFFFFF (CNT_W=32) and trigger another hazard -> stall_cnt remains 0xFFFFFFFF.
